if_fetch: RTL and testbench
===========================

# if_fetch

Instruction-fetch stage of the pipelined MIPS core. Owns the program counter, issues word reads to the instruction memory over a req/ready handshake, and presents one fetched instruction plus its address to the IF/ID pipeline register. Honours the hazard unit's PC stall and the branch redirect. Whenever no valid word is being presented, it raises `fetch_valid` low, and the hazard unit turns that into an IF/ID flush (bubble).

## Interface
Parameters:
- `RESET_PC`, default 32'h0000_0000: PC loaded on reset.
- `NOP_INSN`, default 32'h0000_0000: value driven on `instruction` when nothing valid is held.

Ports:
- `clk`  in  1  Single clock. All state updates on the rising edge.
- `reset`  in  1  Asynchronous, active-low reset.
- `pc_write`  in  1  1 = ID may consume the presented instruction this cycle (IF/ID write enable); 0 = stall.
- `branch_taken`  in  1  Single-cycle redirect pulse.
- `branch_target`  in  32  Redirect address, valid while `branch_taken`=1.
- `imem_req`  out  1  Read request to instruction memory.
- `imem_addr`  out  32  Read address. Stable while `imem_req`=1 until accepted.
- `imem_rdata`  in  32  Read data. Valid in the cycle `imem_ready`=1.
- `imem_ready`  in  1  Memory completes the request at this rising edge.
- `pc`  out  32  Address of the presented instruction. IF/ID adds 4.
- `instruction`  out  32  Presented instruction word.
- `fetch_valid`  out  1  1 = `pc`/`instruction` hold a valid, correct-path word.

## Operation
- Registers:
  - `pc_reg`: 32-bit, drives `imem_addr` and `pc`.
  - `insn_reg`: 32-bit.
  - `redirect_pc`: 32-bit.
  - `valid_reg`.
  - A 2-bit state: REQ, HOLD, DROP.
- Reset (`reset`=0, immediate, asynchronous):
  - State = REQ, `pc_reg` = RESET_PC, `insn_reg` = NOP_INSN, `valid_reg` = 0, `redirect_pc` = 0.
  - `imem_req` is forced to 0 while reset is asserted.
- Outputs:
  - `imem_req` = 1 in REQ and DROP, 0 in HOLD.
  - `imem_addr` = `pc_reg`.
  - `instruction` = `insn_reg`.
  - `fetch_valid` = `valid_reg`.
- REQ:
  - `imem_ready`=1 and `branch_taken`=0: `insn_reg` <= `imem_rdata`, `valid_reg` <= 1, go to HOLD.
  - `imem_ready`=1 and `branch_taken`=1: discard the data, `pc_reg` <= `branch_target`, stay in REQ.
  - `imem_ready`=0 and `branch_taken`=1: `redirect_pc` <= `branch_target`, go to DROP. The address must stay stable, so the outstanding read is finished and then dropped.
  - `imem_ready`=0 and `branch_taken`=0: hold.
  - `pc_write` is ignored in REQ.
- HOLD:
  - `branch_taken`=1: `pc_reg` <= `branch_target`, `valid_reg` <= 0, `insn_reg` <= NOP_INSN, go to REQ. Branch has priority over `pc_write`; the held word is wrong-path.
  - Else `pc_write`=1: the word is consumed by IF/ID at this edge. `pc_reg` <= `pc_reg` + 4 (mod 2^32, 32'hFFFF_FFFC wraps to 0), `valid_reg` <= 0, `insn_reg` <= NOP_INSN, go to REQ.
  - Else: hold everything (stall of any length).
- DROP:
  - `imem_ready`=0: stay in DROP. If `branch_taken`=1, `redirect_pc` <= `branch_target` (latest redirect wins).
  - `imem_ready`=1: discard `imem_rdata`, go to REQ. `pc_reg` <= `branch_target` if `branch_taken`=1, else `redirect_pc`.
  - `valid_reg` stays 0 throughout DROP.
- `imem_rdata` is never captured in HOLD or DROP.

## Timing
- Latency, with `imem_ready` tied to 1:
  - Request at cycle N, `fetch_valid`=1 from cycle N+1.
  - Consumed at the first edge with `pc_write`=1.
  - Next request in the following cycle.
- Peak throughput is one instruction per 2 cycles.
- A memory wait of W cycles adds W cycles per fetch.
- Redirect to first valid target word:
  - From HOLD, or from REQ with ready: 2 cycles.
  - From REQ without ready: the remaining wait, plus 1 cycle for the drop, plus the target fetch.
- Handshake rule: once `imem_req`=1, `imem_addr` is held unchanged until the edge where `imem_ready`=1. This holds through branches and through `pc_write`.
- Reset mid-operation clears the state to REQ at RESET_PC immediately. An outstanding memory read is abandoned; the memory must tolerate `imem_req` dropping under reset.
- Outputs are register-driven only (no combinational input-to-output path), except that `imem_req` is gated by reset.

## Test plan
- Reset release, `imem_ready`=1, `pc_write`=1, memory word = address: `imem_addr` = 0, 4, 8, … on alternate cycles. `fetch_valid` toggles 1/0. The `pc`/`instruction` pairs are (0,0), (4,4), (8,8).
- Stall: `pc_write`=0 for 5 cycles while in HOLD at pc=8. `pc`, `instruction` and `fetch_valid`=1 stay constant and `imem_req`=0. One cycle after `pc_write` returns to 1, `imem_addr`=12.
- Redirect from HOLD with `branch_taken`=1 and `pc_write`=1, target 32'h40: `fetch_valid` drops. The next `imem_addr`=32'h40 and pc+4 is not fetched.
- Redirect during a waited read: `imem_ready`=0 for 3 cycles at addr 16, with branch to 32'h80 in wait cycle 1 and branch to 32'h100 in wait cycle 2.
  - `imem_addr` stays 16 until ready, and that data is dropped.
  - Next fetch is at 32'h100.
  - `fetch_valid`=0 throughout.
- Wrap: RESET_PC=32'hFFFF_FFFC, consume one word. The next `imem_addr`=0.
- Async reset pulse in the middle of DROP: outputs go immediately to `imem_req`=0, `pc`=RESET_PC, `fetch_valid`=0, `instruction`=NOP_INSN. After release, the fetch restarts at RESET_PC.

Source files
------------

// File: rtl/if_fetch.sv
// if_fetch: MIPS instruction-fetch stage; owns the PC and fetches one word at a time over a req/ready memory port.
// Latency: a word is presented 1 cycle after memory accepts the request; memory waits add 1:1. Peak rate is 1 word / 2 cycles.
// Backpressure: pc_write=0 holds the presented word indefinitely. The memory port holds imem_addr stable until imem_ready.
//
// Ports:
//   clk, reset                 clock; asynchronous active-low reset
//   pc_write                   IF/ID write enable (0 = stall)
//   branch_taken/target        single-cycle redirect
//   imem_req/addr/rdata/ready  instruction memory read handshake
//   pc/instruction/fetch_valid word presented to IF/ID (fetch_valid=0 means bubble)
module if_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INSN = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        pc_write,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        imem_ready,
  output logic [31:0] pc,
  output logic [31:0] instruction,
  output logic        fetch_valid
);

  localparam logic [1:0] S_REQ  = 2'd0;  // read outstanding at pc_reg
  localparam logic [1:0] S_HOLD = 2'd1;  // presenting a fetched word
  localparam logic [1:0] S_DROP = 2'd2;  // finishing a wrong-path read

  logic [1:0]  state;
  logic [31:0] pc_reg;
  logic [31:0] insn_reg;
  logic [31:0] redirect_pc;
  logic        valid_reg;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= S_REQ;
      pc_reg      <= RESET_PC;
      insn_reg    <= NOP_INSN;
      redirect_pc <= 32'h0000_0000;
      valid_reg   <= 1'b0;
    end else begin
      case (state)
        S_REQ: begin
          if (imem_ready) begin
            if (branch_taken) begin
              // Read completes this edge, so the address is free to move.
              pc_reg <= branch_target;
            end else begin
              insn_reg  <= imem_rdata;
              valid_reg <= 1'b1;
              state     <= S_HOLD;
            end
          end else if (branch_taken) begin
            // Address must stay put until the read finishes; park the target.
            redirect_pc <= branch_target;
            state       <= S_DROP;
          end
        end
        S_HOLD: begin
          // Branch wins over pc_write: the held word is wrong-path.
          if (branch_taken || pc_write) begin
            pc_reg    <= branch_taken ? branch_target : pc_reg + 32'd4;
            valid_reg <= 1'b0;
            insn_reg  <= NOP_INSN;
            state     <= S_REQ;
          end
        end
        S_DROP: begin
          if (imem_ready) begin
            pc_reg <= branch_taken ? branch_target : redirect_pc;
            state  <= S_REQ;
          end else if (branch_taken) begin
            redirect_pc <= branch_target;
          end
        end
        default: state <= S_REQ;
      endcase
    end
  end

  assign imem_req    = reset && (state != S_HOLD);
  assign imem_addr   = pc_reg;
  assign pc          = pc_reg;
  assign instruction = insn_reg;
  assign fetch_valid = valid_reg;

endmodule

// File: tb/tb_if_fetch.sv
// Testbench for if_fetch: directed scenarios followed by randomized traffic.
// Expected consumed words come from a program-flow model: sequential +4 unless a
// redirect (latest wins) or reset intervenes.
module tb_if_fetch;

  logic        clk = 1'b0;
  logic        reset;
  logic        pc_write;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        imem_ready;
  logic [31:0] pc;
  logic [31:0] instruction;
  logic        fetch_valid;

  // Second instance exercising the PC wrap and a non-zero NOP value.
  localparam logic [31:0] W_RESET = 32'hFFFF_FFFC;
  localparam logic [31:0] W_NOP   = 32'h0000_0020;
  logic        w_req;
  logic [31:0] w_addr;
  logic [31:0] w_rdata;
  logic [31:0] w_pc;
  logic [31:0] w_insn;
  logic        w_valid;

  logic [31:0] garbage;
  logic [31:0] exp_q[$];
  int          tests = 0;
  int          fails = 0;
  int          rst_count = 0;
  int          mon_rst_seen = 0;
  logic        pend_prev = 1'b0;
  logic [31:0] pend_addr = 32'h0;
  logic [31:0] e;

  if_fetch dut (
    .clk(clk), .reset(reset), .pc_write(pc_write),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .imem_ready(imem_ready), .pc(pc), .instruction(instruction),
    .fetch_valid(fetch_valid)
  );

  if_fetch #(.RESET_PC(W_RESET), .NOP_INSN(W_NOP)) dut_w (
    .clk(clk), .reset(reset), .pc_write(1'b1),
    .branch_taken(1'b0), .branch_target(32'h0),
    .imem_req(w_req), .imem_addr(w_addr), .imem_rdata(w_rdata),
    .imem_ready(1'b1), .pc(w_pc), .instruction(w_insn),
    .fetch_valid(w_valid)
  );

  always #5 clk = ~clk;

  // Memory contents: unique per word, never equal to either NOP value.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {~a[31:2], 2'b11};
  endfunction

  always @(posedge clk) garbage <= $urandom;
  always_comb imem_rdata = imem_ready ? mem_word(imem_addr) : garbage;
  assign w_rdata = mem_word(w_addr);

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
    end
  endtask

  task automatic drive_branch(input logic bt, input logic [31:0] tgt);
    branch_taken  = bt;
    branch_target = tgt;
    if (bt) begin
      exp_q.delete();
      exp_q.push_back(tgt);
    end
  endtask

  task automatic assert_reset();
    reset = 1'b0;
    rst_count++;
    exp_q.delete();
    exp_q.push_back(32'h0000_0000);
  endtask

  // Monitor: checks every consumed word against the scoreboard and watches
  // the memory handshake. Samples on the falling edge.
  always @(negedge clk) begin
    if (reset && mon_rst_seen == rst_count) begin
      if (pend_prev) begin
        check("hs_req_held", {31'h0, imem_req}, 32'h1);
        check("hs_addr_stable", imem_addr, pend_addr);
      end
      if (!fetch_valid) check("idle_insn_nop", instruction, 32'h0);
      if (fetch_valid && pc_write && !branch_taken) begin
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL consume_unexpected: got pc %h, expected no word", pc);
        end else begin
          e = exp_q.pop_front();
          check("consume_pc", pc, e);
          check("consume_insn", instruction, mem_word(e));
          exp_q.push_back(e + 32'd4);
        end
      end
      pend_prev = imem_req && !imem_ready;
      pend_addr = imem_addr;
    end else begin
      pend_prev    = 1'b0;
      mon_rst_seen = rst_count;
    end
  end

  initial begin
    pc_write   = 1'b1;
    imem_ready = 1'b1;
    drive_branch(1'b0, 32'h0);
    assert_reset();
    repeat (3) @(negedge clk);
    check("rst_req", {31'h0, imem_req}, 32'h0);
    check("rst_pc", pc, 32'h0);
    check("rst_valid", {31'h0, fetch_valid}, 32'h0);
    check("rst_insn", instruction, 32'h0);
    check("rst_w_pc", w_pc, W_RESET);
    check("rst_w_insn", w_insn, W_NOP);
    check("rst_w_req", {31'h0, w_req}, 32'h0);
    @(posedge clk); #1 reset = 1'b1;

    // Back-to-back fetches with ready=1: alternating request / present.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("seq_req", {31'h0, imem_req}, 32'h1);
      check("seq_addr", imem_addr, 32'(4 * i));
      check("seq_valid_lo", {31'h0, fetch_valid}, 32'h0);
      if (i == 0) check("wrap_addr_start", w_addr, W_RESET);
      if (i == 1) check("wrap_addr_zero", w_addr, 32'h0);
      @(posedge clk); #1 pc_write = (i < 2);
      @(negedge clk);
      check("seq_valid_hi", {31'h0, fetch_valid}, 32'h1);
      check("seq_pc", pc, 32'(4 * i));
      check("seq_insn", instruction, mem_word(32'(4 * i)));
      check("seq_req_lo", {31'h0, imem_req}, 32'h0);
      if (i == 0) begin
        check("wrap_valid", {31'h0, w_valid}, 32'h1);
        check("wrap_insn", w_insn, mem_word(W_RESET));
      end
    end

    // Stall in HOLD at pc=8.
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("stall_pc", pc, 32'h8);
      check("stall_valid", {31'h0, fetch_valid}, 32'h1);
      check("stall_req", {31'h0, imem_req}, 32'h0);
      check("stall_insn", instruction, mem_word(32'h8));
    end
    @(posedge clk); #1 pc_write = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("unstall_addr", imem_addr, 32'hC);
    check("unstall_req", {31'h0, imem_req}, 32'h1);

    // Redirect from HOLD with pc_write=1.
    @(posedge clk); #1 drive_branch(1'b1, 32'h40);
    @(posedge clk); #1 drive_branch(1'b0, 32'h0);
    @(negedge clk);
    check("redir_valid_lo", {31'h0, fetch_valid}, 32'h0);
    check("redir_addr", imem_addr, 32'h40);
    @(negedge clk);
    check("redir_pc", pc, 32'h40);
    check("redir_valid_hi", {31'h0, fetch_valid}, 32'h1);

    // Redirects during a waited read at 0x44; latest target wins.
    @(posedge clk); #1 imem_ready = 1'b0; drive_branch(1'b1, 32'h80);
    @(negedge clk); check("wait_addr0", imem_addr, 32'h44);
    @(posedge clk); #1 drive_branch(1'b1, 32'h100);
    @(negedge clk); check("wait_addr1", imem_addr, 32'h44);
    @(posedge clk); #1 drive_branch(1'b0, 32'h0);
    @(negedge clk); check("wait_addr2", imem_addr, 32'h44);
    check("wait_valid", {31'h0, fetch_valid}, 32'h0);
    @(posedge clk); #1 imem_ready = 1'b1;
    @(negedge clk); check("wait_addr3", imem_addr, 32'h44);
    check("wait_req", {31'h0, imem_req}, 32'h1);
    @(negedge clk); check("drop_next_addr", imem_addr, 32'h100);
    check("drop_valid", {31'h0, fetch_valid}, 32'h0);
    @(negedge clk); check("drop_target_pc", pc, 32'h100);
    check("drop_target_valid", {31'h0, fetch_valid}, 32'h1);

    // Asynchronous reset in the middle of DROP.
    @(posedge clk); #1 imem_ready = 1'b0; drive_branch(1'b1, 32'h200);
    @(posedge clk); #1 drive_branch(1'b0, 32'h0);
    @(negedge clk); check("pre_rst_addr", imem_addr, 32'h104);
    #2 assert_reset();
    #1;
    check("arst_req", {31'h0, imem_req}, 32'h0);
    check("arst_pc", pc, 32'h0);
    check("arst_valid", {31'h0, fetch_valid}, 32'h0);
    check("arst_insn", instruction, 32'h0);
    @(posedge clk); #1 reset = 1'b1; imem_ready = 1'b1;
    @(negedge clk); check("arst_restart_addr", imem_addr, 32'h0);
    check("arst_restart_req", {31'h0, imem_req}, 32'h1);
    @(negedge clk); check("arst_restart_pc", pc, 32'h0);
    check("arst_restart_valid", {31'h0, fetch_valid}, 32'h1);

    // Randomized traffic, checked by the monitor.
    for (int n = 0; n < 4000; n++) begin
      @(posedge clk); #1;
      pc_write   = ($urandom_range(0, 99) < 60);
      imem_ready = ($urandom_range(0, 99) < 65);
      if ($urandom_range(0, 299) == 0) begin
        drive_branch(1'b0, 32'h0);
        assert_reset();
        #2 reset = 1'b1;
      end else if ($urandom_range(0, 99) < 8) begin
        drive_branch(1'b1, $urandom & 32'hFFFF_FFFC);
      end else begin
        drive_branch(1'b0, 32'h0);
      end
    end
    @(posedge clk); #1;
    drive_branch(1'b0, 32'h0);
    pc_write = 1'b0;
    repeat (3) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
